dmem_lsu_ctrl: RTL and testbench

Load/store sequencer between the core's MEM stage and the data memory.
- Accepts one byte-addressed load/store request (LB/LH/LW/LBU/LHU/SB/SH/SW) and drives the memory's word-addressed port.
- Data memory honours only the lowest set lane of its byte mask per write, so this block serialises stores into one single-lane write per byte.
- Returns extended load data through a single-cycle response pulse.

---
 rtl/dmem_lsu_pkg.sv | 43 ++++
 rtl/dmem_lsu_align.sv | 27 ++
 rtl/dmem_lsu_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dmem_lsu_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the data-memory load/store sequencer: funct3 values,
// access sizes, the sequencer state set and memory-control levels.
package dmem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] SIZE_B = 3'd1;
    localparam logic [2:0] SIZE_H = 3'd2;
    localparam logic [2:0] SIZE_W = 3'd4;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD0,
        CAP0,
        RD1,
        CAP1,
        RESP
    } lsu_state_t;

    // Unlisted funct3 codes, and any store with funct3[2] set, fall back to a word access.
    function automatic logic [2:0] size_decode(input logic [2:0] funct3, input logic is_store);
        logic [2:0] sz;
        sz = SIZE_W;
        if (!(is_store && funct3[2])) begin
            case (funct3)
                F3_B, F3_BU: sz = SIZE_B;
                F3_H, F3_HU: sz = SIZE_H;
                F3_W:        sz = SIZE_W;
                default:     sz = SIZE_W;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Load-data aligner: merges two little-endian words from a byte lane and
// sign- or zero-extends the selected bytes to 32 bits.
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] w0,
    input  logic [31:0] w1,
    input  logic [1:0]  lane,
    input  logic [2:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] rdata
);

    logic [31:0] merged;

    always_comb begin
        merged = 32'({w1, w0} >> {lane, 3'b000});
        case (size)
            SIZE_B:  rdata = is_unsigned ? {24'b0, merged[7:0]}
                                         : {{24{merged[7]}}, merged[7:0]};
            SIZE_H:  rdata = is_unsigned ? {16'b0, merged[15:0]}
                                         : {{16{merged[15]}}, merged[15:0]};
            default: rdata = merged;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between MEM stage and word-addressed data memory.
// Misaligned H/W accesses are executed only when DMEM_LSU_MISALIGN_EN is defined.
module dmem_lsu_ctrl
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic              req_is_store,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_wren,
    output logic              mem_is_load,
    output logic [3:0]        mem_mask,
    output logic [ADDR_W-3:0] mem_r_addr,
    output logic [ADDR_W-3:0] mem_w_addr,
    output logic [DATA_W-1:0] mem_w_data,
    input  logic [DATA_W-1:0] mem_r_data
);

    localparam int WORD_W = ADDR_W - 2;

    lsu_state_t        state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        size_q;
    logic              uns_q;
    logic              store_q;
    logic [1:0]        cnt_q;
    logic [DATA_W-1:0] w0_q;
    logic [DATA_W-1:0] w1_use;
    logic [DATA_W-1:0] load_data;
    logic              rsp_err;
    logic              accept;
    logic [2:0]        req_size;
    logic [ADDR_W-1:0] byte_addr;
    logic [WORD_W-1:0] word_q;
    logic [1:0]        lane_q;
    logic              last_byte;

`ifdef DMEM_LSU_MISALIGN_EN
    logic [DATA_W-1:0] w1_q;
    logic              q_mis;
    assign q_mis   = ({1'b0, lane_q} + size_q) > SIZE_W;
    assign w1_use  = w1_q;
    assign rsp_err = DISABLE;
`else
    logic              err_q;
    logic              req_mis;
    assign req_mis = ({1'b0, req_addr[1:0]} + req_size) > SIZE_W;
    assign w1_use  = '0;
    assign rsp_err = err_q;
`endif

    assign accept    = req_valid && (state == IDLE);
    assign req_size  = size_decode(req_funct3, req_is_store);
    assign byte_addr = addr_q + ADDR_W'(cnt_q);
    assign word_q    = addr_q[ADDR_W-1:2];
    assign lane_q    = addr_q[1:0];
    assign last_byte = ({1'b0, cnt_q} == (size_q - 3'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            store_q <= 1'b0;
            cnt_q   <= '0;
            w0_q    <= '0;
`ifdef DMEM_LSU_MISALIGN_EN
            w1_q    <= '0;
`else
            err_q   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                size_q  <= req_size;
                uns_q   <= req_funct3[2];
                store_q <= req_is_store;
                cnt_q   <= '0;
`ifndef DMEM_LSU_MISALIGN_EN
                err_q   <= req_mis;
`endif
            end
            if (state == WR) cnt_q <= cnt_q + 2'd1;
            if (state == CAP0) w0_q <= mem_r_data;
`ifdef DMEM_LSU_MISALIGN_EN
            if (state == CAP1) w1_q <= mem_r_data;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = req_is_store ? WR : RD0;
`ifndef DMEM_LSU_MISALIGN_EN
                    if (req_mis) state_nx = RESP;
`endif
                end
            end
            WR:   if (last_byte) state_nx = RESP;
            RD0:  state_nx = CAP0;
`ifdef DMEM_LSU_MISALIGN_EN
            CAP0: state_nx = q_mis ? RD1 : RESP;
            RD1:  state_nx = CAP1;
            CAP1: state_nx = RESP;
`else
            CAP0: state_nx = RESP;
`endif
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state == IDLE);
        resp_valid  = DISABLE;
        resp_rdata  = '0;
        resp_err    = DISABLE;
        mem_wren    = DISABLE;
        mem_is_load = DISABLE;
        mem_mask    = '0;
        mem_r_addr  = '0;
        mem_w_addr  = '0;
        mem_w_data  = '0;
        case (state)
            WR: begin
                mem_wren   = ENABLE;
                mem_w_addr = byte_addr[ADDR_W-1:2];
                mem_mask   = 4'b0001 << byte_addr[1:0];
                mem_w_data = {{(DATA_W-8){1'b0}}, wdata_q[8*cnt_q +: 8]} << {byte_addr[1:0], 3'b000};
            end
            RD0: begin
                mem_is_load = ENABLE;
                mem_r_addr  = word_q;
            end
`ifdef DMEM_LSU_MISALIGN_EN
            RD1: begin
                mem_is_load = ENABLE;
                mem_r_addr  = word_q + WORD_W'(1);
            end
`endif
            RESP: begin
                resp_valid = ENABLE;
                resp_err   = rsp_err;
                if (!store_q && !rsp_err) resp_rdata = load_data;
            end
            default: ;
        endcase
    end

    dmem_lsu_align u_align (
        .w0          (w0_q),
        .w1          (w1_use),
        .lane        (lane_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .rdata       (load_data)
    );

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Self-checking bench for dmem_lsu_ctrl: byte-level reference memory plus a
// behavioural memory model; follows DMEM_LSU_MISALIGN_EN like the design.
module tb_dmem_lsu_ctrl;

    localparam int ADDR_W = 7;
`ifdef DMEM_LSU_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic        req_is_store;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wren;
    logic        mem_is_load;
    logic [3:0]  mem_mask;
    logic [4:0]  mem_r_addr;
    logic [4:0]  mem_w_addr;
    logic [31:0] mem_w_data;
    logic [31:0] mem_r_data;

    int unsigned n_vec;
    int unsigned n_err;
    logic [7:0]  env_mem [128];
    logic [7:0]  ref_mem [128];
    logic [31:0] got;

    always #5 clk = ~clk;

    dmem_lsu_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct3   (req_funct3),
        .req_is_store (req_is_store),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_wren     (mem_wren),
        .mem_is_load  (mem_is_load),
        .mem_mask     (mem_mask),
        .mem_r_addr   (mem_r_addr),
        .mem_w_addr   (mem_w_addr),
        .mem_w_data   (mem_w_data),
        .mem_r_data   (mem_r_data)
    );

    // Memory behaviour: only the lowest set lane is written; read data is registered.
    always @(posedge clk) begin
        if (mem_wren) begin
            for (int l = 0; l < 4; l++) begin
                if (mem_mask[l]) begin
                    env_mem[{mem_w_addr, 2'(l)}] <= mem_w_data[8*l +: 8];
                    break;
                end
            end
        end
        if (mem_is_load)
            mem_r_data <= {env_mem[{mem_r_addr, 2'd3}], env_mem[{mem_r_addr, 2'd2}],
                           env_mem[{mem_r_addr, 2'd1}], env_mem[{mem_r_addr, 2'd0}]};
        else
            mem_r_data <= $urandom;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        req_valid    = 1'($urandom);
        req_is_store = 1'($urandom);
        req_funct3   = 3'($urandom);
        req_addr     = 7'($urandom);
        req_wdata    = $urandom;
    endtask

    function automatic int unsigned ref_size(input logic [2:0] f3, input bit st);
        if (f3 == 3'b000 || (!st && f3 == 3'b100)) return 1;
        if (f3 == 3'b001 || (!st && f3 == 3'b101)) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [6:0] addr);
        logic [31:0] v;
        int unsigned sz;
        v  = '0;
        sz = ref_size(f3, 1'b0);
        for (int i = 0; i < int'(sz); i++)
            v = v | (32'(ref_mem[(int'(addr) + i) % 128]) << (8 * i));
        if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic do_req(input bit st, input logic [2:0] f3, input logic [6:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd);
        int unsigned sz, lane, a, word;
        bit          mis;
        logic [7:0]  b;
        logic [31:0] exp;
        sz   = ref_size(f3, st);
        lane = int'(addr) % 4;
        mis  = (lane + sz) > 4;
        word = int'(addr) / 4;
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wd;
        check("c0_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (mis && !MIS_EN) begin
            check("err_resp_valid", 32'(resp_valid), 32'd1);
            check("err_resp_err", 32'(resp_err), 32'd1);
            check("err_rdata", resp_rdata, 32'd0);
            check("err_wren", 32'(mem_wren), 32'd0);
            check("err_is_load", 32'(mem_is_load), 32'd0);
            check("err_ready", 32'(req_ready), 32'd0);
            rd = resp_rdata;
            scramble();
        end else if (st) begin
            for (int unsigned k = 0; k < sz; k++) begin
                a = (int'(addr) + k) % 128;
                b = wd[8*k +: 8];
                check("st_wren", 32'(mem_wren), 32'd1);
                check("st_is_load", 32'(mem_is_load), 32'd0);
                check("st_w_addr", 32'(mem_w_addr), a / 4);
                check("st_mask", 32'(mem_mask), 32'd1 << (a % 4));
                check("st_w_data", mem_w_data, 32'(b) << (8 * (a % 4)));
                check("st_ready", 32'(req_ready), 32'd0);
                check("st_no_resp", 32'(resp_valid), 32'd0);
                ref_mem[a] = b;
                scramble();
                @(negedge clk);
            end
            check("st_resp_valid", 32'(resp_valid), 32'd1);
            check("st_resp_err", 32'(resp_err), 32'd0);
            check("st_rdata", resp_rdata, 32'd0);
            check("st_resp_wren", 32'(mem_wren), 32'd0);
            rd = resp_rdata;
            scramble();
        end else begin
            exp = ref_load(f3, addr);
            check("ld_rd0_is_load", 32'(mem_is_load), 32'd1);
            check("ld_rd0_r_addr", 32'(mem_r_addr), word);
            check("ld_rd0_wren", 32'(mem_wren), 32'd0);
            check("ld_rd0_ready", 32'(req_ready), 32'd0);
            scramble();
            @(negedge clk);
            check("ld_cap0_is_load", 32'(mem_is_load), 32'd0);
            check("ld_cap0_no_resp", 32'(resp_valid), 32'd0);
            scramble();
            if (mis) begin
                @(negedge clk);
                check("ld_rd1_is_load", 32'(mem_is_load), 32'd1);
                check("ld_rd1_r_addr", 32'(mem_r_addr), (word + 1) % 32);
                check("ld_rd1_no_resp", 32'(resp_valid), 32'd0);
                scramble();
                @(negedge clk);
                check("ld_cap1_is_load", 32'(mem_is_load), 32'd0);
                check("ld_cap1_no_resp", 32'(resp_valid), 32'd0);
                scramble();
            end
            @(negedge clk);
            check("ld_resp_valid", 32'(resp_valid), 32'd1);
            check("ld_resp_err", 32'(resp_err), 32'd0);
            check("ld_rdata", resp_rdata, exp);
            check("ld_resp_ready", 32'(req_ready), 32'd0);
            rd = resp_rdata;
            scramble();
        end
        @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_no_resp", 32'(resp_valid), 32'd0);
        req_valid = 1'b0;
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_funct3   = '0;
        req_addr     = '0;
        req_wdata    = '0;
        for (int i = 0; i < 128; i++) begin
            env_mem[i] = 8'($urandom);
            ref_mem[i] = env_mem[i];
        end

        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_wren", 32'(mem_wren), 32'd0);
        check("rst_is_load", 32'(mem_is_load), 32'd0);
        check("rst_mask", 32'(mem_mask), 32'd0);
        check("rst_r_addr", 32'(mem_r_addr), 32'd0);
        check("rst_w_addr", 32'(mem_w_addr), 32'd0);
        check("rst_w_data", mem_w_data, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_req(1'b1, 3'b010, 7'h10, 32'hDEADBEEF, got);
        do_req(1'b0, 3'b000, 7'h13, 32'h0, got);
        check("lb_0x13", got, 32'hFFFFFFDE);
        do_req(1'b0, 3'b100, 7'h13, 32'h0, got);
        check("lbu_0x13", got, 32'h000000DE);
        do_req(1'b1, 3'b001, 7'h0E, 32'h00001234, got);
        do_req(1'b0, 3'b001, 7'h0E, 32'h0, got);
        check("lh_0x0e", got, 32'h00001234);
`ifdef DMEM_LSU_MISALIGN_EN
        do_req(1'b1, 3'b010, 7'h7E, 32'hA1B2C3D4, got);
        do_req(1'b0, 3'b010, 7'h7E, 32'h0, got);
        check("lw_0x7e_wrap", got, 32'hA1B2C3D4);
`else
        do_req(1'b0, 3'b010, 7'h05, 32'h0, got);
        check("lw_0x05_err_rdata", got, 32'h0);
`endif

        for (int n = 0; n < 60; n++)
            do_req(1'($urandom), 3'($urandom), 7'($urandom), $urandom, got);

        // Reset lands as the cycle-2 write commits: bytes 0 and 1 persist, 2 and 3 do not.
        req_valid    = 1'b1;
        req_is_store = 1'b1;
        req_funct3   = 3'b010;
        req_addr     = 7'h20;
        req_wdata    = 32'h55667788;
        check("mid_rst_c0_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_rst_c1_wren", 32'(mem_wren), 32'd1);
        check("mid_rst_c1_mask", 32'(mem_mask), 32'd1);
        @(negedge clk);
        check("mid_rst_c2_wren", 32'(mem_wren), 32'd1);
        check("mid_rst_c2_mask", 32'(mem_mask), 32'd2);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_wren", 32'(mem_wren), 32'd0);
        check("mid_rst_mask", 32'(mem_mask), 32'd0);
        check("mid_rst_w_data", mem_w_data, 32'd0);
        check("mid_rst_resp", 32'(resp_valid), 32'd0);
        check("mid_rst_is_load", 32'(mem_is_load), 32'd0);
        ref_mem[32] = 8'h88;
        ref_mem[33] = 8'h77;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_no_resp", 32'(resp_valid), 32'd0);
            check("post_rst_no_wren", 32'(mem_wren), 32'd0);
            check("post_rst_ready", 32'(req_ready), 32'd1);
        end

        for (int i = 0; i < 128; i++)
            check("mem_sweep", 32'(env_mem[i]), 32'(ref_mem[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
